formant_segmenter: RTL and testbench

- Parametrised dynamic-programming segmentation engine for the formant path.
- Accepts a streamed triangular table of segment costs E(j,i), computes the optimal split of bins 0..I-1 into a run-time-selected number of contiguous segments, and streams the segment start boundaries out through traceback.
- Successor to the fixed-FORMANTS DP/traceback stage. It adds run-time segment count, valid/ready handshakes on both sides, saturating arithmetic, abort, and reporting of the minimum cost.

---
 rtl/formant_segmenter.sv | 192 +++++++++++++++++++
 tb/tb_formant_segmenter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/formant_segmenter.sv
// Dynamic-programming segmentation engine: accumulates a streamed triangular cost table
// into F/B tables, then traces back and streams the optimal segment start bins.
module formant_segmenter #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int MAX_SEGS  = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    input  logic [$clog2(MAX_SEGS+1)-1:0] num_segs_in,
    input  logic                          abort_in,
    input  logic                          cost_valid,
    output logic                          cost_ready,
    input  logic [BIT_WIDTH-1:0]          cost_data,
    output logic                          bound_valid,
    input  logic                          bound_ready,
    output logic [$clog2(I)-1:0]          bound_data,
    output logic [$clog2(MAX_SEGS)-1:0]   bound_idx,
    output logic                          bound_last,
    output logic [BIT_WIDTH-1:0]          min_cost,
    output logic                          busy,
    output logic                          error
);

    localparam int KW = $clog2(MAX_SEGS + 1);
    localparam int IW = $clog2(I);
    localparam int SW = $clog2(MAX_SEGS);
    localparam logic [BIT_WIDTH-1:0] INF = '1;

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_WRITE, S_TRACE, S_DONE} state_t;

    state_t               state;
    logic [KW-1:0]        k_sel;
    logic [KW-1:0]        k_cur;
    logic [IW-1:0]        row_i;
    logic [IW-1:0]        col_j;
    logic [IW-1:0]        end_bin;
    logic [BIT_WIDTH-1:0] run_min [MAX_SEGS];
    logic [IW-1:0]        run_arg [MAX_SEGS];
    logic [BIT_WIDTH-1:0] f_mem   [MAX_SEGS][I];
    logic [IW-1:0]        b_mem   [MAX_SEGS][I];
    logic [BIT_WIDTH-1:0] cand    [MAX_SEGS];
    logic [IW-1:0]        j_m1;
    logic [SW-1:0]        kc_m1;
    logic [SW-1:0]        ks_m1;
    logic                 k_ok;

    function automatic logic [BIT_WIDTH-1:0] sat_add(input logic [BIT_WIDTH-1:0] a,
                                                     input logic [BIT_WIDTH-1:0] b);
        logic [BIT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (a == INF || b == INF || s[BIT_WIDTH]) return INF;
        return s[BIT_WIDTH-1:0];
    endfunction

    assign j_m1  = col_j - IW'(1);
    assign kc_m1 = SW'(k_cur - KW'(1));
    assign ks_m1 = SW'(k_sel - KW'(1));
    assign k_ok  = (int'(num_segs_in) >= 1) && (int'(num_segs_in) <= MAX_SEGS) &&
                   (int'(num_segs_in) <= I);

    // Candidate for segment count k+1 given the beat E(col_j, row_i).
    always_comb begin
        for (int k = 0; k < MAX_SEGS; k++) begin
            cand[k] = INF;
            if (k == 0) begin
                if (col_j == '0) cand[k] = cost_data;
            end else if (int'(col_j) >= k) begin
                cand[k] = sat_add(f_mem[k-1][j_m1], cost_data);
            end
        end
    end

    // NOTE: F/B are plain storage with no reset; every entry traceback reads is written first.
    always_ff @(posedge clk_in) begin
        if (state == S_WRITE) begin
            for (int k = 0; k < MAX_SEGS; k++) begin
                if (k < int'(k_sel)) begin
                    f_mem[k][row_i] <= run_min[k];
                    b_mem[k][row_i] <= run_arg[k];
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= S_IDLE;
            k_sel       <= '0;
            k_cur       <= '0;
            row_i       <= '0;
            col_j       <= '0;
            end_bin     <= '0;
            cost_ready  <= 1'b0;
            bound_valid <= 1'b0;
            bound_data  <= '0;
            bound_idx   <= '0;
            bound_last  <= 1'b0;
            min_cost    <= '0;
            busy        <= 1'b0;
            error       <= 1'b0;
            for (int k = 0; k < MAX_SEGS; k++) begin
                run_min[k] <= INF;
                run_arg[k] <= IW'(k);
            end
        end else begin
            error <= 1'b0;
            if (abort_in) begin
                state       <= S_IDLE;
                busy        <= 1'b0;
                cost_ready  <= 1'b0;
                bound_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_in) begin
                            if (k_ok) begin
                                k_sel      <= num_segs_in;
                                row_i      <= '0;
                                col_j      <= '0;
                                busy       <= 1'b1;
                                cost_ready <= 1'b1;
                                state      <= S_ACCUM;
                                for (int k = 0; k < MAX_SEGS; k++) begin
                                    run_min[k] <= INF;
                                    run_arg[k] <= IW'(k);
                                end
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    S_ACCUM: begin
                        if (cost_valid) begin
                            // Strict compare keeps the smallest j on ties.
                            for (int k = 0; k < MAX_SEGS; k++) begin
                                if (cand[k] < run_min[k]) begin
                                    run_min[k] <= cand[k];
                                    run_arg[k] <= col_j;
                                end
                            end
                            if (col_j == row_i) begin
                                cost_ready <= 1'b0;
                                state      <= S_WRITE;
                            end else begin
                                col_j <= col_j + IW'(1);
                            end
                        end
                    end
                    S_WRITE: begin
                        for (int k = 0; k < MAX_SEGS; k++) begin
                            run_min[k] <= INF;
                            run_arg[k] <= IW'(k);
                        end
                        if (row_i != IW'(I - 1)) begin
                            row_i      <= row_i + IW'(1);
                            col_j      <= '0;
                            cost_ready <= 1'b1;
                            state      <= S_ACCUM;
                        end else begin
                            k_cur   <= k_sel;
                            end_bin <= IW'(I - 1);
                            state   <= S_TRACE;
                        end
                    end
                    S_TRACE: begin
                        if (!bound_valid) begin
                            bound_data  <= b_mem[kc_m1][end_bin];
                            bound_idx   <= kc_m1;
                            bound_last  <= (k_cur == KW'(1));
                            min_cost    <= f_mem[ks_m1][IW'(I - 1)];
                            bound_valid <= 1'b1;
                        end else if (bound_ready) begin
                            bound_valid <= 1'b0;
                            if (k_cur == KW'(1)) begin
                                busy  <= 1'b0;
                                state <= S_DONE;
                            end else begin
                                end_bin <= bound_data - IW'(1);
                                k_cur   <= k_cur - KW'(1);
                            end
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_formant_segmenter.sv
// Scoreboard bench for formant_segmenter with I=4, MAX_SEGS=4, BIT_WIDTH=8.
module tb_formant_segmenter;

    localparam int BW = 8;
    localparam int NI = 4;
    localparam int MS = 4;

    typedef struct {
        logic [1:0]    idx;
        logic [1:0]    data;
        logic          last;
        logic [BW-1:0] minc;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          start_in = 1'b0;
    logic [2:0]    num_segs_in = '0;
    logic          abort_in = 1'b0;
    logic          cost_valid = 1'b0;
    logic          cost_ready;
    logic [BW-1:0] cost_data = '0;
    logic          bound_valid;
    logic          bound_ready = 1'b1;
    logic [1:0]    bound_data;
    logic [1:0]    bound_idx;
    logic          bound_last;
    logic [BW-1:0] min_cost;
    logic          busy;
    logic          error;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    logic [BW-1:0] tab [NI][NI];

    formant_segmenter #(.BIT_WIDTH(BW), .I(NI), .MAX_SEGS(MS)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .num_segs_in(num_segs_in),
        .abort_in(abort_in), .cost_valid(cost_valid), .cost_ready(cost_ready),
        .cost_data(cost_data), .bound_valid(bound_valid), .bound_ready(bound_ready),
        .bound_data(bound_data), .bound_idx(bound_idx), .bound_last(bound_last),
        .min_cost(min_cost), .busy(busy), .error(error)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input int data, input bit last, input int mc);
        exp_t e;
        e.idx  = 2'(idx);
        e.data = 2'(data);
        e.last = last;
        e.minc = BW'(mc);
        sb.push_back(e);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NI; j++) tab[j][i] = BW'(v);
    endtask

    task automatic fill_square();
        for (int i = 0; i < NI; i++)
            for (int j = 0; j <= i; j++) tab[j][i] = BW'((i - j + 1) * (i - j + 1));
        tab[0][1] = 8'd1;
        tab[2][3] = 8'd1;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run(input int k, input bit gaps, input bit hold);
        int waits;
        int n;
        waits       = 0;
        bound_ready = !hold;
        num_segs_in = 3'(k);
        start_in    = 1'b1;
        tick();
        start_in = 1'b0;
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j <= i; j++) begin
                if (gaps && $urandom_range(1) == 1) begin
                    cost_valid = 1'b0;
                    tick();
                end
                cost_valid = 1'b1;
                cost_data  = tab[j][i];
                n = 0;
                while (!cost_ready && n < 50) begin
                    tick();
                    n++;
                end
                waits += n;
                if (n >= 50) check("cost_ready_timeout", cost_ready, 1);
                tick();
            end
        end
        cost_valid = 1'b0;
        if (!gaps) check("accum_stalls", waits, NI - 1);
        if (hold) begin
            n = 0;
            while (!bound_valid && n < 100) begin
                tick();
                n++;
            end
            check("first_bound_seen", bound_valid, 1);
            repeat (5) tick();
            bound_ready = 1'b1;
        end
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("run_done", busy, 0);
        check("sb_drained", sb.size(), 0);
        tick();
    endtask

    // Monitor: pops expectations on each transfer and checks stability while stalled.
    initial begin
        bit         held;
        logic [1:0] h_data;
        logic [1:0] h_idx;
        logic       h_last;
        exp_t       e;
        held = 1'b0;
        forever begin
            @(negedge clk_in);
            if (bound_valid) begin
                if (held) begin
                    check("stall_data", bound_data, h_data);
                    check("stall_idx", bound_idx, h_idx);
                    check("stall_last", bound_last, h_last);
                end
                if (!bound_ready) begin
                    held   = 1'b1;
                    h_data = bound_data;
                    h_idx  = bound_idx;
                    h_last = bound_last;
                end else begin
                    held = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_beat", bound_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("bound_idx", bound_idx, e.idx);
                        check("bound_data", bound_data, e.data);
                        check("bound_last", bound_last, e.last);
                        check("min_cost", min_cost, e.minc);
                    end
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_cost_ready", cost_ready, 0);
        check("rst_bound_valid", bound_valid, 0);
        check("rst_bound_data", bound_data, 0);
        check("rst_bound_idx", bound_idx, 0);
        check("rst_bound_last", bound_last, 0);
        check("rst_min_cost", min_cost, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        repeat (2) tick();
        rst_in = 1'b1;
        tick();

        fill_const(0);
        push(1, 1, 0, 0);
        push(0, 0, 1, 0);
        run(2, 0, 0);

        push(2, 2, 0, 0);
        push(1, 1, 0, 0);
        push(0, 0, 1, 0);
        run(3, 0, 0);

        fill_square();
        push(1, 2, 0, 2);
        push(0, 0, 1, 2);
        run(2, 0, 0);

        fill_const(8'hF0);
        push(1, 1, 0, 8'hFF);
        push(0, 0, 1, 8'hFF);
        run(2, 0, 0);

        fill_square();
        push(1, 2, 0, 2);
        push(0, 0, 1, 2);
        run(2, 1, 0);

        fill_const(0);
        push(1, 1, 0, 0);
        push(0, 0, 1, 0);
        run(2, 0, 1);

        for (int t = 0; t < 2; t++) begin
            num_segs_in = (t == 0) ? 3'd0 : 3'(MS + 1);
            start_in    = 1'b1;
            tick();
            start_in = 1'b0;
            check("reject_error", error, 1);
            check("reject_busy", busy, 0);
            tick();
            check("error_one_cycle", error, 0);
            check("reject_stays_idle", busy, 0);
        end

        num_segs_in = 3'd2;
        start_in    = 1'b1;
        tick();
        start_in   = 1'b0;
        cost_valid = 1'b1;
        cost_data  = '0;
        repeat (3) tick();
        abort_in = 1'b1;
        tick();
        abort_in   = 1'b0;
        cost_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_cost_ready", cost_ready, 0);
        repeat (3) tick();

        start_in = 1'b1;
        tick();
        start_in   = 1'b0;
        cost_valid = 1'b1;
        repeat (3) tick();
        rst_in = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_cost_ready", cost_ready, 0);
        check("reset_bound_valid", bound_valid, 0);
        tick();
        cost_valid = 1'b0;
        rst_in     = 1'b1;
        tick();

        fill_square();
        push(1, 2, 0, 2);
        push(0, 0, 1, 2);
        run(2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
